// File: rtl/ex_hazard_sched.sv
// EX-stage hazard controller: operand forwarding, load-use/redirect stall+flush, MUL/DIV start/done sequencing with watchdog.
// Optional perf counters are built when HZD_PERF_CNT_EN is defined; otherwise the counter ports read 0.
module ex_hazard_sched #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  RS1_D_i,
    input  logic [4:0]  RS2_D_i,
    input  logic [4:0]  RS1_E_i,
    input  logic [4:0]  RS2_E_i,
    input  logic [4:0]  RD_E_i,
    input  logic [1:0]  RSLTSRC_E_i,
    input  logic [4:0]  RD_M_i,
    input  logic        REGWRT_M_i,
    input  logic [4:0]  RD_W_i,
    input  logic        REGWRT_W_i,
    input  logic [1:0]  PCSRC_E_i,
    input  logic        MULDIV_E_i,
    input  logic        MD_DONE_i,
    output logic        MD_START_o,
    output logic [1:0]  FRWRDA_E_o,
    output logic [1:0]  FRWRDB_E_o,
    output logic        STALL_F_o,
    output logic        STALL_D_o,
    output logic        STALL_E_o,
    output logic        FLUSH_D_o,
    output logic        FLUSH_E_o,
    output logic        BUSY_o,
    output logic        MD_ERR_o,
    output logic [31:0] STALL_CNT_o,
    output logic [31:0] FLUSH_CNT_o
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(MD_TIMEOUT - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic          r_md_err, w_md_err_nxt;
    logic          w_md_start, w_md_stall;
    logic          w_load_use, w_redirect;

    // M-stage result is newer than W, so it wins when both match
    always_comb begin
        FRWRDA_E_o = 2'b00;
        if (REGWRT_M_i && RD_M_i != 5'd0 && RD_M_i == RS1_E_i)      FRWRDA_E_o = 2'b10;
        else if (REGWRT_W_i && RD_W_i != 5'd0 && RD_W_i == RS1_E_i) FRWRDA_E_o = 2'b01;
    end

    always_comb begin
        FRWRDB_E_o = 2'b00;
        if (REGWRT_M_i && RD_M_i != 5'd0 && RD_M_i == RS2_E_i)      FRWRDB_E_o = 2'b10;
        else if (REGWRT_W_i && RD_W_i != 5'd0 && RD_W_i == RS2_E_i) FRWRDB_E_o = 2'b01;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
            r_md_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            r_md_err <= w_md_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_md_err_nxt = r_md_err;
        w_md_start   = 1'b0;
        w_md_stall   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // a taken branch in E squashes the MUL/DIV, so never launch it
                if (MULDIV_E_i && PCSRC_E_i == 2'b00) begin
                    w_md_start   = 1'b1;
                    w_md_stall   = 1'b1;
                    w_state_nxt  = S_BUSY;
                    w_to_cnt_nxt = '0;
                end
            end
            S_BUSY: begin
                if (MD_DONE_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_md_stall = 1'b1;
                    if (r_to_cnt == TO_LAST) begin
                        w_state_nxt  = S_IDLE;
                        w_md_err_nxt = 1'b1;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_load_use = (RSLTSRC_E_i == 2'b01) && (RD_E_i != 5'd0) &&
                        ((RD_E_i == RS1_D_i) || (RD_E_i == RS2_D_i));
    assign w_redirect = (PCSRC_E_i != 2'b00);

    // MUL/DIV occupancy holds E, so it dominates both load-use and redirect
    assign MD_START_o = rst_i & w_md_start;
    assign STALL_F_o  = rst_i & (w_md_stall | (w_load_use & ~w_redirect));
    assign STALL_D_o  = rst_i & (w_md_stall | (w_load_use & ~w_redirect));
    assign STALL_E_o  = rst_i & w_md_stall;
    assign FLUSH_D_o  = rst_i & ~w_md_stall & w_redirect;
    assign FLUSH_E_o  = rst_i & ~w_md_stall & (w_redirect | w_load_use);
    assign BUSY_o     = rst_i & (r_state == S_BUSY);
    assign MD_ERR_o   = r_md_err;

`ifdef HZD_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (STALL_D_o && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((FLUSH_D_o || FLUSH_E_o) && r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign STALL_CNT_o = r_stall_cnt;
    assign FLUSH_CNT_o = r_flush_cnt;
`else
    assign STALL_CNT_o = 32'h0;
    assign FLUSH_CNT_o = 32'h0;
`endif

endmodule

// File: tb/tb_ex_hazard_sched.sv
// Scoreboard bench for ex_hazard_sched: directed vectors push expected outputs, a negedge monitor pops and compares.
// Counter expectations follow HZD_PERF_CNT_EN the same way the design does.
module tb_ex_hazard_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  RS1_D_i, RS2_D_i, RS1_E_i, RS2_E_i, RD_E_i, RD_M_i, RD_W_i;
    logic [1:0]  RSLTSRC_E_i, PCSRC_E_i;
    logic        REGWRT_M_i, REGWRT_W_i, MULDIV_E_i, MD_DONE_i;
    logic        MD_START_o, STALL_F_o, STALL_D_o, STALL_E_o, FLUSH_D_o, FLUSH_E_o, BUSY_o, MD_ERR_o;
    logic [1:0]  FRWRDA_E_o, FRWRDB_E_o;
    logic [31:0] STALL_CNT_o, FLUSH_CNT_o;

    ex_hazard_sched #(.MD_TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RS1_D_i(RS1_D_i), .RS2_D_i(RS2_D_i), .RS1_E_i(RS1_E_i), .RS2_E_i(RS2_E_i),
        .RD_E_i(RD_E_i), .RSLTSRC_E_i(RSLTSRC_E_i), .RD_M_i(RD_M_i), .REGWRT_M_i(REGWRT_M_i),
        .RD_W_i(RD_W_i), .REGWRT_W_i(REGWRT_W_i), .PCSRC_E_i(PCSRC_E_i), .MULDIV_E_i(MULDIV_E_i),
        .MD_DONE_i(MD_DONE_i), .MD_START_o(MD_START_o),
        .FRWRDA_E_o(FRWRDA_E_o), .FRWRDB_E_o(FRWRDB_E_o),
        .STALL_F_o(STALL_F_o), .STALL_D_o(STALL_D_o), .STALL_E_o(STALL_E_o),
        .FLUSH_D_o(FLUSH_D_o), .FLUSH_E_o(FLUSH_E_o), .BUSY_o(BUSY_o), .MD_ERR_o(MD_ERR_o),
        .STALL_CNT_o(STALL_CNT_o), .FLUSH_CNT_o(FLUSH_CNT_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  fwd;
        logic [7:0]  ctl;   // {start,busy,err,stF,stD,stE,flD,flE}
        logic [63:0] cnt;   // {stall_cnt, flush_cnt}
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stall_tally = 0;
    int    flush_tally = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        RS1_D_i = 0; RS2_D_i = 0; RS1_E_i = 0; RS2_E_i = 0; RD_E_i = 0; RD_M_i = 0; RD_W_i = 0;
        RSLTSRC_E_i = 0; PCSRC_E_i = 0; REGWRT_M_i = 0; REGWRT_W_i = 0; MULDIV_E_i = 0; MD_DONE_i = 0;
    endtask

    // Push the hand-computed outputs for the vector just applied.
    task automatic chk(input string nm, input logic [3:0] fwd, input logic [7:0] ctl);
        exp_t e;
        e.fwd = fwd;
        e.ctl = ctl;
        if (!rst_i) begin
            stall_tally = 0;
            flush_tally = 0;
        end
`ifdef HZD_PERF_CNT_EN
        e.cnt = {32'(stall_tally), 32'(flush_tally)};
`else
        e.cnt = 64'h0;
`endif
        if (rst_i) begin
            stall_tally += int'(ctl[3]);
            flush_tally += int'(ctl[1] | ctl[0]);
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic [7:0] act_ctl;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act_ctl = {MD_START_o, BUSY_o, MD_ERR_o, STALL_F_o, STALL_D_o, STALL_E_o, FLUSH_D_o, FLUSH_E_o};
            checks++;
            if ({FRWRDA_E_o, FRWRDB_E_o} !== e.fwd) begin
                errors++;
                $display("FAIL %s fwd: got %b want %b", nm, {FRWRDA_E_o, FRWRDB_E_o}, e.fwd);
            end
            checks++;
            if (act_ctl !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b want %b", nm, act_ctl, e.ctl);
            end
            checks++;
            if ({STALL_CNT_o, FLUSH_CNT_o} !== e.cnt) begin
                errors++;
                $display("FAIL %s cnt: got %0d/%0d want %0d/%0d", nm,
                         STALL_CNT_o, FLUSH_CNT_o, e.cnt[63:32], e.cnt[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        rst_i = 1'b0;
        tick();
        // reset: forwarding stays live, control forced low even with a redirect pending
        RS1_E_i = 5; RD_M_i = 5; REGWRT_M_i = 1; PCSRC_E_i = 2'b01;
        chk("reset", 4'b1000, 8'b0000_0000);

        tick(); rst_i = 1'b1; clr();
        RS1_E_i = 5; RD_M_i = 5; REGWRT_M_i = 1; RD_W_i = 5; REGWRT_W_i = 1;
        chk("fwd_m", 4'b1000, 8'b0000_0000);
        tick(); REGWRT_M_i = 0;
        chk("fwd_w", 4'b0100, 8'b0000_0000);
        tick(); REGWRT_M_i = 1; RD_M_i = 0; RD_W_i = 0; RS1_E_i = 0;
        chk("fwd_x0", 4'b0000, 8'b0000_0000);
        tick(); RS1_E_i = 3; RS2_E_i = 9; RD_M_i = 3; RD_W_i = 9;
        chk("fwd_ab", 4'b1001, 8'b0000_0000);
        tick(); RS2_E_i = 3; RD_W_i = 3;
        chk("fwd_m_pri", 4'b1010, 8'b0000_0000);

        tick(); clr(); RSLTSRC_E_i = 2'b01; RD_E_i = 7; RS2_D_i = 7;
        chk("lu_rs2", 4'b0000, 8'b0001_1001);
        tick(); RS2_D_i = 0; RS1_D_i = 7;
        chk("lu_rs1", 4'b0000, 8'b0001_1001);
        tick(); RD_E_i = 0; RS1_D_i = 0;
        chk("lu_x0", 4'b0000, 8'b0000_0000);
        tick(); RSLTSRC_E_i = 2'b00; RD_E_i = 7; RS1_D_i = 7;
        chk("not_load", 4'b0000, 8'b0000_0000);
        tick(); RSLTSRC_E_i = 2'b01; PCSRC_E_i = 2'b01;
        chk("redir_lu", 4'b0000, 8'b0000_0011);
        tick(); RSLTSRC_E_i = 2'b00; PCSRC_E_i = 2'b10;
        chk("redir", 4'b0000, 8'b0000_0011);
        tick(); RSLTSRC_E_i = 2'b01; PCSRC_E_i = 2'b00;
        chk("lu_3", 4'b0000, 8'b0001_1001);

        // counters now 3 stalls / 5 flushes; DONE in IDLE must be ignored
        tick(); clr(); MD_DONE_i = 1;
        chk("done_idle", 4'b0000, 8'b0000_0000);
        tick(); MD_DONE_i = 0; MULDIV_E_i = 1; PCSRC_E_i = 2'b01;
        chk("md_redir", 4'b0000, 8'b0000_0011);
        tick(); PCSRC_E_i = 2'b00;
        chk("md_start", 4'b0000, 8'b1001_1100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("md_busy", 4'b0000, 8'b0101_1100);
        end
        tick(); MD_DONE_i = 1;
        chk("md_done", 4'b0000, 8'b0100_0000);
        tick(); MD_DONE_i = 0; MULDIV_E_i = 0;
        chk("md_idle", 4'b0000, 8'b0000_0000);

        // watchdog abort after 4 BUSY cycles
        tick(); MULDIV_E_i = 1;
        chk("to_start", 4'b0000, 8'b1001_1100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_busy", 4'b0000, 8'b0101_1100);
        end
        tick(); MULDIV_E_i = 0;
        chk("to_abort", 4'b0000, 8'b0010_0000);
        tick(); RSLTSRC_E_i = 2'b01; RD_E_i = 4; RS1_D_i = 4;
        chk("err_sticky", 4'b0000, 8'b0011_1001);

        // reset in the middle of BUSY releases everything at once
        tick(); clr(); MULDIV_E_i = 1;
        chk("rr_start", 4'b0000, 8'b1011_1100);
        tick();
        chk("rr_busy", 4'b0000, 8'b0111_1100);
        tick(); rst_i = 1'b0;
        chk("rr_reset", 4'b0000, 8'b0000_0000);
        tick(); rst_i = 1'b1; MULDIV_E_i = 0;
        chk("rr_idle", 4'b0000, 8'b0000_0000);
        tick(); MULDIV_E_i = 1;
        chk("min_start", 4'b0000, 8'b1001_1100);
        tick(); MD_DONE_i = 1;
        chk("min_done", 4'b0000, 8'b0100_0000);
        tick(); clr();
        chk("final", 4'b0000, 8'b0000_0000);

        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
